// File: rtl/plugboard_pairing_if.sv
// Channel A/B letter strobes plus configuration and status signals of the plugboard stage.
interface plugboard_pairing_if;
  logic        cfg_mode;
  logic        clear_pairs;
  logic        a_valid;
  logic [25:0] a_in;
  logic        a_out_valid;
  logic [25:0] a_out;
  logic        b_valid;
  logic [25:0] b_in;
  logic        b_out_valid;
  logic [25:0] b_out;
  logic [3:0]  pair_count;
  logic        pending;
  logic [25:0] pending_letter;
  logic        err;
  logic [1:0]  err_code;

  modport master (
    output cfg_mode, clear_pairs, a_valid, a_in, b_valid, b_in,
    input  a_out_valid, a_out, b_out_valid, b_out,
           pair_count, pending, pending_letter, err, err_code
  );

  modport slave (
    input  cfg_mode, clear_pairs, a_valid, a_in, b_valid, b_in,
    output a_out_valid, a_out, b_out_valid, b_out,
           pair_count, pending, pending_letter, err, err_code
  );
endinterface

// File: rtl/plugboard_pairing.sv
// Registered Steckerbrett: two lookup lanes over a shared swap map, plus the
// channel-A pair-configuration FSM that builds the map at runtime.
module plugboard_lane #(
  parameter int VEC_W = 26
) (
  input  logic [VEC_W-1:0]      letter,
  input  logic [VEC_W-1:0][4:0] map,
  output logic [VEC_W-1:0]      sub
);
  always_comb begin
    sub = '0;
    if ($onehot(letter))
      for (int i = 0; i < VEC_W; i++)
        if (letter[i]) sub = VEC_W'(1) << map[i];
  end
endmodule

module plugboard_pairing #(
  parameter int MAX_PAIRS = 10
) (
  input logic             CLOCK_50,
  input logic             reset,
  plugboard_pairing_if.slave bus
);
  localparam int NUM_LANES = 2;
  localparam int VEC_W     = 26;

  typedef enum logic [1:0] {RUN, WAIT_FIRST, WAIT_SECOND} state_t;

  state_t                          state;
  logic [VEC_W-1:0][4:0]           map_q;
  logic [4:0]                      first_idx;
  logic [NUM_LANES-1:0][VEC_W-1:0] lane_in, lane_sub;
  logic                            key_oh;
  logic [4:0]                      key_idx;

  // lane 0 = channel A, lane 1 = channel B
  assign lane_in = {bus.b_in, bus.a_in};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    plugboard_lane #(.VEC_W(VEC_W)) u_lane (
      .letter (lane_in[g]),
      .map    (map_q),
      .sub    (lane_sub[g])
    );
  end

  always_comb begin
    key_oh  = $onehot(bus.a_in);
    key_idx = '0;
    for (int i = 0; i < VEC_W; i++)
      if (bus.a_in[i]) key_idx = 5'(i);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state              <= RUN;
      for (int i = 0; i < VEC_W; i++) map_q[i] <= 5'(i);
      first_idx          <= '0;
      bus.a_out_valid    <= 1'b0;
      bus.a_out          <= '0;
      bus.b_out_valid    <= 1'b0;
      bus.b_out          <= '0;
      bus.pair_count     <= '0;
      bus.pending        <= 1'b0;
      bus.pending_letter <= '0;
      bus.err            <= 1'b0;
      bus.err_code       <= '0;
    end else begin
      bus.a_out_valid <= bus.a_valid & ~bus.cfg_mode;
      if (bus.a_valid && !bus.cfg_mode) bus.a_out <= lane_sub[0];
      bus.b_out_valid <= bus.b_valid;
      if (bus.b_valid) bus.b_out <= lane_sub[1];
      bus.err <= 1'b0;

      if (bus.clear_pairs) begin
        for (int i = 0; i < VEC_W; i++) map_q[i] <= 5'(i);
        bus.pair_count     <= '0;
        bus.pending        <= 1'b0;
        bus.pending_letter <= '0;
        state              <= bus.cfg_mode ? WAIT_FIRST : RUN;
      end else if (!bus.cfg_mode) begin
        state              <= RUN;
        bus.pending        <= 1'b0;
        bus.pending_letter <= '0;
      end else begin
        if (state == RUN) state <= WAIT_FIRST;
        if (bus.a_valid) begin
          if (!key_oh) begin
            bus.err      <= 1'b1;
            bus.err_code <= 2'd1;
          end else if (state != WAIT_SECOND) begin
            // a key arriving on the cfg_mode rising edge counts as a first letter
            if (bus.pair_count == 4'(MAX_PAIRS)) begin
              bus.err      <= 1'b1;
              bus.err_code <= 2'd3;
            end else if (map_q[key_idx] != key_idx) begin
              bus.err      <= 1'b1;
              bus.err_code <= 2'd2;
            end else begin
              state              <= WAIT_SECOND;
              first_idx          <= key_idx;
              bus.pending        <= 1'b1;
              bus.pending_letter <= bus.a_in;
            end
          end else if (map_q[key_idx] != key_idx || key_idx == first_idx) begin
            bus.err      <= 1'b1;
            bus.err_code <= 2'd2;
          end else begin
            map_q[first_idx]   <= key_idx;
            map_q[key_idx]     <= first_idx;
            bus.pair_count     <= bus.pair_count + 4'd1;
            bus.pending        <= 1'b0;
            bus.pending_letter <= '0;
            state              <= WAIT_FIRST;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_plugboard_pairing.sv
// Scoreboarded bench: stimulus pushes expected lookups from a letter-array model,
// a negedge monitor pops and compares whenever a DUT output strobe appears.
module tb_plugboard_pairing;
  localparam int MAXP = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  plugboard_pairing_if bus();

  plugboard_pairing #(.MAX_PAIRS(MAXP)) dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .bus      (bus)
  );

  int          pmap[26];
  int          m_pairs, m_first, m_code;
  bit          m_pend, m_err;
  logic [25:0] qa[$], qb[$];
  int          n_tests = 0, n_fail = 0;

  function automatic logic [25:0] oh(input int i);
    logic [25:0] one = 26'd1;
    return one << i;
  endfunction

  function automatic int nbits(input logic [25:0] v);
    int n = 0;
    for (int i = 0; i < 26; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic int first_set(input logic [25:0] v);
    for (int i = 0; i < 26; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [25:0] model_lookup(input logic [25:0] v);
    if (nbits(v) != 1) return 26'h0;
    return oh(pmap[first_set(v)]);
  endfunction

  task automatic identity();
    for (int i = 0; i < 26; i++) pmap[i] = i;
    m_pairs = 0;
    m_pend  = 0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit cm, input bit clr, input bit av,
                            input logic [25:0] ai, input bit r);
    int k;
    if (r) begin
      identity();
      m_err = 0; m_code = 0; m_first = 0;
      return;
    end
    m_err = 0;
    if (clr) identity();
    else if (!cm) m_pend = 0;
    else if (av) begin
      k = first_set(ai);
      if (nbits(ai) != 1) begin m_err = 1; m_code = 1; end
      else if (!m_pend) begin
        if (m_pairs == MAXP)  begin m_err = 1; m_code = 3; end
        else if (pmap[k] != k) begin m_err = 1; m_code = 2; end
        else begin m_pend = 1; m_first = k; end
      end else if (pmap[k] != k || k == m_first) begin
        m_err = 1; m_code = 2;
      end else begin
        pmap[m_first] = k;
        pmap[k]       = m_first;
        m_pairs++;
        m_pend = 0;
      end
    end
  endtask

  task automatic cyc(input bit cm, input bit clr, input bit av, input logic [25:0] ai,
                     input bit bv, input logic [25:0] bi, input bit r);
    bus.cfg_mode = cm; bus.clear_pairs = clr;
    bus.a_valid = av;  bus.a_in = ai;
    bus.b_valid = bv;  bus.b_in = bi;
    rst = r;
    if (!r) begin
      if (av && !cm) qa.push_back(model_lookup(ai));
      if (bv)        qb.push_back(model_lookup(bi));
    end
    model_step(cm, clr, av, ai, r);
    @(posedge clk); #1;
    chk("pair_count", 32'(bus.pair_count), 32'(m_pairs));
    chk("pending", 32'(bus.pending), 32'(m_pend));
    chk("pending_letter", 32'(bus.pending_letter), m_pend ? 32'(oh(m_first)) : 32'h0);
    chk("err", 32'(bus.err), 32'(m_err));
    chk("err_code", 32'(bus.err_code), 32'(m_code));
  endtask

  task automatic key(input int i);
    cyc(1, 0, 1, oh(i), 0, 26'h0, 0);
  endtask

  task automatic idle(input bit cm);
    cyc(cm, 0, 0, 26'h0, 0, 26'h0, 0);
  endtask

  always @(negedge clk) begin
    if (bus.a_out_valid === 1'b1) begin
      if (qa.size() == 0) chk("a_out_valid_spurious", 32'd1, 32'd0);
      else chk("a_out", 32'(bus.a_out), 32'(qa.pop_front()));
    end
    if (bus.b_out_valid === 1'b1) begin
      if (qb.size() == 0) chk("b_out_valid_spurious", 32'd1, 32'd0);
      else chk("b_out", 32'(bus.b_out), 32'(qb.pop_front()));
    end
  end

  initial begin
    logic [25:0] ai, bi;
    bit cm, clr, av, bv, r;
    bus.cfg_mode = 0; bus.clear_pairs = 0; bus.a_valid = 0; bus.a_in = '0;
    bus.b_valid = 0; bus.b_in = '0; rst = 1;

    cyc(0, 0, 0, 26'h0, 0, 26'h0, 1);
    cyc(0, 0, 0, 26'h0, 0, 26'h0, 1);
    chk("rst_a_out", 32'(bus.a_out), 32'h0);
    chk("rst_b_out", 32'(bus.b_out), 32'h0);
    chk("rst_valids", {30'h0, bus.a_out_valid, bus.b_out_valid}, 32'h0);

    // identity lookups, including a zero input on channel A
    cyc(0, 0, 1, 26'h0, 1, 26'h4, 0);
    idle(0);
    chk("b_out_hold", 32'(bus.b_out), 32'h4);

    // pair A<->Z
    idle(1);
    key(0);
    idle(1);
    key(25);
    cyc(0, 0, 1, 26'h1, 1, 26'h2000000, 0);
    idle(0);

    // rejections: plugged letter, non-one-hot, repeated letter
    idle(1);
    key(0);
    cyc(1, 0, 1, 26'h3, 0, 26'h0, 0);
    key(1);
    key(1);
    key(2);

    // abort a half pair, D must still map to itself
    key(3);
    idle(0);
    cyc(0, 0, 1, oh(3), 1, oh(1), 0);

    // fill the table, then one more first letter
    cyc(1, 1, 0, 26'h0, 1, oh(0), 0);
    for (int i = 0; i < 20; i++) key(i);
    key(20);
    cyc(0, 0, 1, oh(7), 1, oh(18), 0);

    // three pairs, clear with a same-edge lookup, then identity
    cyc(1, 1, 0, 26'h0, 0, 26'h0, 0);
    for (int i = 20; i < 26; i++) key(i);
    cyc(0, 1, 1, oh(20), 1, oh(25), 0);
    cyc(0, 0, 1, oh(20), 1, oh(25), 0);

    // reset while pending with channel B strobing
    idle(1);
    key(4);
    cyc(1, 0, 0, 26'h0, 1, oh(9), 1);
    chk("rst_mid_b_valid", 32'(bus.b_out_valid), 32'h0);
    chk("rst_mid_b_out", 32'(bus.b_out), 32'h0);
    cyc(0, 0, 0, 26'h0, 0, 26'h0, 0);

    for (int n = 0; n < 3000; n++) begin
      cm  = ($urandom_range(0, 9) < 7);
      clr = ($urandom_range(0, 60) == 0);
      r   = ($urandom_range(0, 400) == 0);
      av  = $urandom_range(0, 1) == 1;
      bv  = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 9))
        0:       ai = 26'h0;
        1:       ai = oh($urandom_range(0, 25)) | oh($urandom_range(0, 25));
        default: ai = oh($urandom_range(0, 25));
      endcase
      bi = ($urandom_range(0, 7) == 0) ? 26'($urandom) : oh($urandom_range(0, 25));
      cyc(cm, clr, av, ai, bv, bi, r);
    end
    idle(0);
    idle(0);
    chk("qa_drained", 32'(qa.size()), 32'd0);
    chk("qb_drained", 32'(qb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/plugboard_pairing.md
# plugboard_pairing

Registered Steckerbrett stage for the Enigma datapath, with a runtime pair-configuration state machine.
- Channel A sits between the PS/2 letter decoder and the rotor/reflector stage. It substitutes each typed one-hot letter before it enters the rotors.
- Channel B substitutes the rotor/reflector output before it reaches the GUI.
- In configuration mode, key presses on channel A are consumed in pairs to build up to 10 reciprocal swaps.

## Interface
Parameters:
- MAX_PAIRS, 10, maximum stored swaps (1..13)

Ports:
- CLOCK_50  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- cfg_mode  in  1  1 = channel A keys configure pairs; 0 = run
- clear_pairs  in  1  one-cycle pulse, restores identity map
- a_valid  in  1  one-cycle strobe: a_in holds a key press
- a_in  in  26  one-hot letter, bit0 = A … bit25 = Z
- a_out_valid  out  1  strobe, substituted channel A letter
- a_out  out  26  substituted one-hot letter
- b_valid  in  1  strobe from rotor/reflector stage
- b_in  in  26  one-hot letter
- b_out_valid  out  1  strobe, substituted channel B letter
- b_out  out  26  substituted one-hot letter
- pair_count  out  4  stored pairs, 0..MAX_PAIRS
- pending  out  1  first letter of a pair captured, awaiting second
- pending_letter  out  26  captured first letter (0 when !pending)
- err  out  1  one-cycle pulse, configuration key rejected
- err_code  out  2  1 invalid one-hot, 2 letter already plugged or same as first, 3 table full; held until next err

## Operation
- Map storage: 26 entries × 5-bit letter index. Reset and clear_pairs load the identity map. Each stored swap writes map[x]=y and map[y]=x.
- Lookup: an input with exactly one bit set outputs one-hot(map[index]). An input with zero bits or more than one bit set outputs 26'h0, and its valid strobe still asserts.
- Channel B is always active, including during cfg_mode.
- Channel A in run mode (cfg_mode=0): lookup as above.
- Channel A in cfg_mode=1: a_valid feeds the FSM and a_out_valid stays 0.
- FSM states:
  - RUN: entered whenever cfg_mode=0.
  - WAIT_FIRST: entered when cfg_mode=1. On a valid letter L, capture it and go to WAIT_SECOND with pending=1.
  - WAIT_SECOND: on a valid letter M, commit the swap, increment pair_count and return to WAIT_FIRST.
- Rejection checks, in priority order:
  - non-one-hot input → code 1
  - pair_count == MAX_PAIRS, checked on the first letter → code 3
  - L or M already mapped to another letter (map[i] != i), or M == L → code 2
- A rejected key leaves the state and map unchanged, so a rejected M stays in WAIT_SECOND.
- Dropping cfg_mode while in WAIT_SECOND discards the half pair: pending=0, pending_letter=0, map unchanged. The FSM moves to RUN on the next edge.
- clear_pairs, from any state:
  - identity map, pair_count=0, pending=0
  - FSM goes to WAIT_FIRST if cfg_mode=1, else RUN
  - any a_valid on the same edge is ignored for configuration.

## Timing
- Reset values: a_out/b_out 26'h0, both valid strobes 0, pair_count 0, pending 0, pending_letter 0, err 0, err_code 0, FSM in RUN, identity map.
- Lookup latency: out_valid and out follow the input strobe by exactly 1 cycle. Back-to-back strobes give back-to-back outputs. Out data holds between strobes.
- Channels A and B are independent and may strobe on the same cycle.
- A swap committed at edge N affects lookups sampled at edge N+1 onward. A lookup sampled at edge N uses the old map.
- clear_pairs behaves the same way: lookups sampled on the clearing edge see the old map.
- err asserts on the edge after the rejected strobe, for exactly 1 cycle.
- pair_count, pending and pending_letter update on the edge that samples the key.
- Reset asserted mid-configuration restores all reset values on that edge, overriding every other input.

## Test plan
- Identity: after reset, b_in=26'h4 (C) with b_valid → one cycle later b_out=26'h4, b_out_valid=1. a_in=26'h0 → a_out=26'h0 with a_out_valid=1.
- Pair A↔Z: cfg_mode=1, keys 26'h1 then 26'h2000000.
  - pending=1 between the two keys; pair_count=1 after the second.
  - cfg_mode=0, a_in=26'h1 → a_out=26'h2000000.
  - b_in=26'h2000000 → b_out=26'h1.
- Rejections:
  - with A↔Z stored, first key 26'h1 → err=1, err_code=2, pair_count stays 1.
  - key 26'h3 → err_code=1.
  - pair B then B again → err_code=2, still pending.
- Full table: store 10 disjoint pairs, then key 26'h100000 (U) → err_code=3, pair_count=10, pending=0.
- Abort and clear:
  - Key D then drop cfg_mode → pending=0, D maps to itself.
  - With 3 pairs stored, pulse clear_pairs → pair_count=0, all lookups identity from the next edge.
- Reset mid-operation: reset asserted while pending=1 and b_valid=1 → next cycle all outputs at reset values, no b_out_valid.
